// File: rtl/phase_uart_streamer_if.sv
// phase_uart_streamer_if: sample input and UART/status output bundle for phase_uart_streamer
// Signals: tick_i/signal_i/enable_i (sample strobe, data, capture enable),
//   uart_tx_o (8N1 line), fifo_level_o (occupancy), overflow_o (sticky drop), busy_o (frame in flight).
// Modports: master drives the sample side, slave is the streamer itself.
interface phase_uart_streamer_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          tick_i;
    logic [15:0]                   signal_i;
    logic                          enable_i;
    logic                          uart_tx_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
    logic                          overflow_o;
    logic                          busy_o;
    modport master (
        output tick_i, signal_i, enable_i,
        input  uart_tx_o, fifo_level_o, overflow_o, busy_o
    );
    modport slave (
        input  tick_i, signal_i, enable_i,
        output uart_tx_o, fifo_level_o, overflow_o, busy_o
    );
endinterface

// File: rtl/phase_uart_streamer.sv
// phase_uart_streamer: decimates phase-error samples, queues them and streams A5-framed bytes over an 8N1 UART
// Ports: clk_i, rst_i (synchronous, active high); bus (slave modport of phase_uart_streamer_if):
//   tick_i/signal_i/enable_i in, uart_tx_o/fifo_level_o/overflow_o/busy_o out.
// Build option: define PHASE_STREAM_CHECKSUM_EN to append signal[15:8]^signal[7:0] as a 4th frame byte.
module phase_uart_streamer #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 1000000,
    parameter int DECIM      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input logic clk_i,
    input logic rst_i,
    phase_uart_streamer_if.slave bus
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int DW = $clog2(BAUD_DIV);
    localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef PHASE_STREAM_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    state_t        state;
    logic [CW-1:0] dec_cnt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          overflow, tx, busy;
    logic [15:0]   frame;
    logic [7:0]    shreg, next_byte;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic          push, pop, full, accept, div_end;

    assign push    = bus.tick_i && bus.enable_i && dec_cnt == CW'(DECIM - 1);
    assign pop     = state == LOAD;
    assign full    = level == LW'(FIFO_DEPTH);
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign accept  = push && (!full || pop);
    assign div_end = div_cnt == DW'(BAUD_DIV - 1);
    // byte that follows byte_idx within the current frame
`ifdef PHASE_STREAM_CHECKSUM_EN
    assign next_byte = byte_idx == 2'd0 ? frame[15:8] :
                       byte_idx == 2'd1 ? frame[7:0] : frame[15:8] ^ frame[7:0];
`else
    assign next_byte = byte_idx == 2'd0 ? frame[15:8] : frame[7:0];
`endif

    always_ff @(posedge clk_i) begin
        if (accept) mem[wr_ptr] <= bus.signal_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (!bus.enable_i) dec_cnt <= '0;
            else if (bus.tick_i) dec_cnt <= push ? '0 : dec_cnt + 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept) overflow <= 1'b1;
            level <= level + LW'(accept) - LW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            frame    <= '0;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            // bit timer free-runs through START/DATA/STOP and restarts at every bit boundary
            div_cnt <= (state == IDLE || state == LOAD || div_end) ? '0 : div_cnt + 1'b1;
            case (state)
                IDLE: if (level != '0) state <= LOAD;
                LOAD: begin
                    frame    <= mem[rd_ptr];
                    shreg    <= 8'hA5;
                    byte_idx <= '0;
                    busy     <= 1'b1;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: if (div_end) begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (div_end) begin
                    bit_idx <= bit_idx + 1'b1;
                    tx      <= bit_idx == 3'd7 ? 1'b1 : shreg[0];
                    shreg   <= shreg >> 1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (div_end) begin
                    if (byte_idx == LAST_BYTE) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        shreg    <= next_byte;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.uart_tx_o    = tx;
    assign bus.fifo_level_o = level;
    assign bus.overflow_o   = overflow;
    assign bus.busy_o       = busy;
endmodule

// File: doc/phase_uart_streamer.md
Name: phase_uart_streamer

Overview:
Sits downstream of the post-PLL low-pass FIR and consumes the filtered 16-bit phase-error samples (signal_phs), which arrive at the 1 MHz tick rate. It decimates the stream, buffers samples in a small FIFO and serialises each one over a UART as a framed byte sequence. A host PC captures this stream for phase-noise spectral analysis. Overflow is flagged sticky so that dropped samples are never silent.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 1000000, UART bit rate; BAUD_DIV = CLK_HZ/BAUD (integer, >= 2)
DECIM, 64, decimation factor applied to tick_i-rate samples (>= 1)
FIFO_DEPTH, 16, sample FIFO depth in 16-bit words (power of 2)

Ports:
clk_i  in  1  system clock, single clock domain
rst_i  in  1  synchronous, active-high reset
tick_i  in  1  one-cycle sample strobe; signal_i is valid in the same cycle
signal_i  in  16  signed phase sample (two's complement)
enable_i  in  1  1 = capture samples; 0 = stop capture and drain the FIFO
uart_tx_o  out  1  UART TX line: 8N1, LSB first, idle high
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_o  out  1  sticky: a sample was dropped because the FIFO was full
busy_o  out  1  high while a frame is being transmitted

Behaviour:
- Reset (rst_i sampled high on a clk_i edge): uart_tx_o=1, fifo_level_o=0, overflow_o=0, busy_o=0, decimation counter=0, FSM=IDLE. Applies mid-frame: the line returns high on the next edge and the partial frame is abandoned.
- Decimator: the counter advances only on tick_i && enable_i. On the tick where count==DECIM-1, signal_i is pushed and the counter wraps to 0. enable_i=0 holds the counter at 0, so the first push after re-enable happens on the DECIM-th tick. DECIM=1 pushes on every tick.
- FIFO: push is written at the clock edge of the push cycle. Occupancy shows the new value the following cycle.
  - Push while full with no pop in the same cycle: the sample is dropped, overflow_o is set, and contents are unchanged.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Pop while empty never occurs.
- Frame format: 3 bytes: 0xA5 sync, signal[15:8], signal[7:0]. Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly BAUD_DIV clocks. Bytes are sent back to back with no idle gap.
- TX FSM:
  - IDLE: if FIFO is non-empty, go to LOAD.
  - LOAD (1 cycle): pop the FIFO head into the frame register, set byte index=0 and busy_o=1.
  - START: drive 0 for BAUD_DIV cycles.
  - DATA: drive 8 bits, BAUD_DIV cycles each.
  - STOP: drive 1 for BAUD_DIV cycles. Then, if more bytes remain in the frame, go to START with byte index+1. Otherwise go to IDLE and clear busy_o.
- Latency: with FSM IDLE and FIFO empty, push at edge N, LOAD during cycle N+1, start bit asserted on uart_tx_o from edge N+2.
- Back-to-back frames: IDLE -> LOAD -> START with no extra idle bits beyond the one IDLE cycle.
- Throughput: at the defaults a frame takes 30 us against a 64 us sample period, so the FIFO must not fill. Smaller DECIM may overflow; this is reported via overflow_o and is not an error.
- enable_i falling mid-frame: the current frame and queued samples are still transmitted; only new captures stop.

Optional Feature:
PHASE_STREAM_CHECKSUM_EN
- Defined: the frame is 4 bytes. A 4th byte, signal[15:8] XOR signal[7:0], follows the LSB byte, sent back to back with the same bit timing.
- Undefined: the frame is 3 bytes and no checksum logic is synthesised.

Test Plan:
1. Reset held, then released with enable_i=0 and ticks running -> uart_tx_o stays 1, fifo_level_o=0, busy_o=0, overflow_o=0 indefinitely.
2. Defaults, enable_i=1, signal_i=16'h1234 on the 64th tick -> decoding uart_tx_o at 1 Mbaud yields bytes A5,12,34. The start bit begins 2 clocks after the push edge. The frame lasts exactly 1500 clocks and busy_o is high throughout. With PHASE_STREAM_CHECKSUM_EN the bytes are A5,12,34,26 over 2000 clocks.
3. DECIM=1, enable_i=1, ticks every 50 clocks, signal_i=-1 (16'hFFFF) -> FIFO fills, so fifo_level_o reaches 16 and overflow_o sets and stays 1. Every frame received is A5,FF,FF. After enable_i=0 the FIFO drains to 0 and the line rests at 1.
4. FIFO full with a push coinciding with a LOAD pop (forced via DECIM=1 and aligned ticks) -> level stays 16, no drop, and overflow_o is unchanged in that cycle.
5. rst_i pulsed during the DATA state of byte 2 -> uart_tx_o=1 and busy_o=0 on the next edge. FIFO and overflow_o are cleared. The next capture produces a clean A5-prefixed frame.
6. enable_i toggled 0->1 -> the first push occurs on exactly the 64th qualifying tick; ticks with enable_i=0 are not counted.
